// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl: central hazard controller for the 5-stage pipeline.
//   Detects load-use hazards and drives the PC, IF/ID and ID/EXE stall/flush
//   controls. Generates EXE operand-forwarding selects. Sequences an orderly
//   halt: it drains the back end with bubbles, then freezes and reports Halted.
// Optional feature: define HAZARD_STALL_COUNT_EN to enable the saturating
//   stall-cycle counter. When it is undefined, StallCount is tied to 0.
// Ports:
//   clock, reset              rising-edge clock, async active-high reset
//   D_Rs/D_Rt, D_UseRs/D_UseRt decode source registers and their use flags
//   D_Halt                    halt instruction in decode
//   E_ReadMem/E_WriteReg/E_REG EXE-stage load/write flags and destination
//   M_WriteReg/M_REG          MEM-stage write flag and destination
//   W_WriteReg/W_REG          WB-stage write flag and destination
//   MemBusy                   data memory not ready, hold the whole pipe
//   PC_Stall, IF_ID_Stall, ID_EXE_Stall, ID_EXE_Flush  buffer controls
//   FwdA/FwdB                 0 = regfile, 1 = MEM result, 2 = WB result
//   Halted                    machine fully stopped
//   StallCount                stall-cycle count (optional feature)
module pipeline_hazard_ctrl #(
  parameter int unsigned DRAIN_CYCLES = 3,
  parameter int unsigned CNT_W        = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [4:0]       D_Rs,
  input  logic [4:0]       D_Rt,
  input  logic             D_UseRs,
  input  logic             D_UseRt,
  input  logic             D_Halt,
  input  logic             E_ReadMem,
  input  logic             E_WriteReg,
  input  logic [4:0]       E_REG,
  input  logic             M_WriteReg,
  input  logic [4:0]       M_REG,
  input  logic             W_WriteReg,
  input  logic [4:0]       W_REG,
  input  logic             MemBusy,
  output logic             PC_Stall,
  output logic             IF_ID_Stall,
  output logic             ID_EXE_Stall,
  output logic             ID_EXE_Flush,
  output logic [1:0]       FwdA,
  output logic [1:0]       FwdB,
  output logic             Halted,
  output logic [CNT_W-1:0] StallCount
);

  localparam int unsigned REG_W  = 5;
  localparam int unsigned DCNT_W = 4;
  localparam logic [DCNT_W-1:0] DRAIN_LAST = DCNT_W'(DRAIN_CYCLES - 1);

  typedef enum logic [1:0] {RUN, DRAIN, HALTED} state_t;

  state_t            state, state_nxt;
  logic [DCNT_W-1:0] drain_cnt, drain_cnt_nxt;
  logic [REG_W-1:0]  e_rs, e_rt;
  logic              load_use;

  // Load in EXE whose destination is read by the instruction in decode
  assign load_use = E_ReadMem & E_WriteReg & (E_REG != '0) &
                    ((D_UseRs & (D_Rs == E_REG)) | (D_UseRt & (D_Rt == E_REG)));

  // State register and drain counter
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= RUN;
      drain_cnt <= '0;
    end else begin
      state     <= state_nxt;
      drain_cnt <= drain_cnt_nxt;
    end
  end

  // Next state and prioritized stall/flush controls; reset forces all low
  always_comb begin
    state_nxt     = state;
    drain_cnt_nxt = drain_cnt;
    PC_Stall      = 1'b0;
    IF_ID_Stall   = 1'b0;
    ID_EXE_Stall  = 1'b0;
    ID_EXE_Flush  = 1'b0;
    Halted        = 1'b0;
    if (reset) begin
      state_nxt = RUN;
    end else if (MemBusy) begin
      PC_Stall     = 1'b1;
      IF_ID_Stall  = 1'b1;
      ID_EXE_Stall = 1'b1;
      Halted       = (state == HALTED);
    end else begin
      case (state)
        HALTED: begin
          PC_Stall     = 1'b1;
          IF_ID_Stall  = 1'b1;
          ID_EXE_Stall = 1'b1;
          Halted       = 1'b1;
        end
        DRAIN: begin
          PC_Stall     = 1'b1;
          IF_ID_Stall  = 1'b1;
          ID_EXE_Flush = 1'b1;
          if (drain_cnt == DRAIN_LAST) begin
            state_nxt     = HALTED;
            drain_cnt_nxt = '0;
          end else begin
            drain_cnt_nxt = drain_cnt + DCNT_W'(1);
          end
        end
        RUN: begin
          // Load-use bubble outranks halt entry; halt is retried next cycle
          if (load_use || D_Halt) begin
            PC_Stall     = 1'b1;
            IF_ID_Stall  = 1'b1;
            ID_EXE_Flush = 1'b1;
          end
          if (!load_use && D_Halt) begin
            // This cycle is drain step 0
            if (DRAIN_LAST == '0) begin
              state_nxt = HALTED;
            end else begin
              state_nxt     = DRAIN;
              drain_cnt_nxt = DCNT_W'(1);
            end
          end
        end
        default: state_nxt = RUN;
      endcase
    end
  end

  // EXE-stage source registers follow the ID/EXE buffer, bubbles carry reg 0
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      e_rs <= '0;
      e_rt <= '0;
    end else if (!ID_EXE_Stall) begin
      e_rs <= ID_EXE_Flush ? '0 : D_Rs;
      e_rt <= ID_EXE_Flush ? '0 : D_Rt;
    end
  end

  // MEM result is newer than WB result, so it wins
  always_comb begin
    FwdA = 2'd0;
    FwdB = 2'd0;
    if (M_WriteReg && (M_REG != '0) && (M_REG == e_rs))      FwdA = 2'd1;
    else if (W_WriteReg && (W_REG != '0) && (W_REG == e_rs)) FwdA = 2'd2;
    if (M_WriteReg && (M_REG != '0) && (M_REG == e_rt))      FwdB = 2'd1;
    else if (W_WriteReg && (W_REG != '0) && (W_REG == e_rt)) FwdB = 2'd2;
  end

`ifdef HAZARD_STALL_COUNT_EN
  logic [CNT_W-1:0] stall_cnt;

  // Saturating count of stalled cycles outside HALTED
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      stall_cnt <= '0;
    end else if (PC_Stall && (state != HALTED) && (stall_cnt != '1)) begin
      stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end

  assign StallCount = stall_cnt;
`else
  assign StallCount = '0;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb_pipeline_hazard_ctrl: directed and random checks of pipeline_hazard_ctrl
// against a cycle-level behavioural model of the hazard and halt rules.
module tb_pipeline_hazard_ctrl;

  localparam int unsigned DRAIN_CYCLES = 3;
  localparam int unsigned CNT_W        = 4;
  localparam int          SC_MAX       = (1 << CNT_W) - 1;

  logic             clock = 1'b0;
  logic             reset;
  logic [4:0]       D_Rs, D_Rt, E_REG, M_REG, W_REG;
  logic             D_UseRs, D_UseRt, D_Halt;
  logic             E_ReadMem, E_WriteReg, M_WriteReg, W_WriteReg, MemBusy;
  logic             PC_Stall, IF_ID_Stall, ID_EXE_Stall, ID_EXE_Flush, Halted;
  logic [1:0]       FwdA, FwdB;
  logic [CNT_W-1:0] StallCount;

  pipeline_hazard_ctrl #(.DRAIN_CYCLES(DRAIN_CYCLES), .CNT_W(CNT_W)) dut (
    .clock(clock), .reset(reset),
    .D_Rs(D_Rs), .D_Rt(D_Rt), .D_UseRs(D_UseRs), .D_UseRt(D_UseRt),
    .D_Halt(D_Halt),
    .E_ReadMem(E_ReadMem), .E_WriteReg(E_WriteReg), .E_REG(E_REG),
    .M_WriteReg(M_WriteReg), .M_REG(M_REG),
    .W_WriteReg(W_WriteReg), .W_REG(W_REG),
    .MemBusy(MemBusy),
    .PC_Stall(PC_Stall), .IF_ID_Stall(IF_ID_Stall),
    .ID_EXE_Stall(ID_EXE_Stall), .ID_EXE_Flush(ID_EXE_Flush),
    .FwdA(FwdA), .FwdB(FwdB), .Halted(Halted), .StallCount(StallCount)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  // Reference model: halted flag, remaining drain cycles, EXE sources, stall count
  bit         m_halted;
  int         m_drain_left;
  logic [4:0] m_ers, m_ert;
  int         m_sc;

  // Expected values for the current cycle
  int e_pc, e_ifid, e_idex, e_flush, e_halted, e_fa, e_fb, e_sc, e_lu;

  task automatic check_eq(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int fwd_model(input logic [4:0] src);
    if (M_WriteReg && M_REG != 0 && M_REG == src) return 1;
    if (W_WriteReg && W_REG != 0 && W_REG == src) return 2;
    return 0;
  endfunction

  task automatic model_reset();
    m_halted     = 1'b0;
    m_drain_left = 0;
    m_ers        = '0;
    m_ert        = '0;
    m_sc         = 0;
  endtask

  task automatic clear_inputs();
    D_Rs = '0; D_Rt = '0; D_UseRs = 0; D_UseRt = 0; D_Halt = 0;
    E_ReadMem = 0; E_WriteReg = 0; E_REG = '0;
    M_WriteReg = 0; M_REG = '0; W_WriteReg = 0; W_REG = '0;
    MemBusy = 0;
  endtask

  // Settle, derive expected outputs from the model and compare every output
  task automatic eval_check();
    #2;
    e_lu = (E_ReadMem && E_WriteReg && E_REG != 0 &&
            ((D_UseRs && D_Rs == E_REG) || (D_UseRt && D_Rt == E_REG))) ? 1 : 0;
    {e_pc, e_ifid, e_idex, e_flush, e_halted} = '0;
    if (reset) begin
      // all controls low
    end else if (MemBusy) begin
      e_pc = 1; e_ifid = 1; e_idex = 1; e_halted = m_halted;
    end else if (m_halted) begin
      e_pc = 1; e_ifid = 1; e_idex = 1; e_halted = 1;
    end else if (m_drain_left > 0 || e_lu == 1 || D_Halt) begin
      e_pc = 1; e_ifid = 1; e_flush = 1;
    end
    e_fa = fwd_model(reset ? 5'd0 : m_ers);
    e_fb = fwd_model(reset ? 5'd0 : m_ert);
`ifdef HAZARD_STALL_COUNT_EN
    e_sc = reset ? 0 : m_sc;
`else
    e_sc = 0;
`endif
    check_eq("PC_Stall", int'(PC_Stall), e_pc);
    check_eq("IF_ID_Stall", int'(IF_ID_Stall), e_ifid);
    check_eq("ID_EXE_Stall", int'(ID_EXE_Stall), e_idex);
    check_eq("ID_EXE_Flush", int'(ID_EXE_Flush), e_flush);
    check_eq("Halted", int'(Halted), e_halted);
    check_eq("FwdA", int'(FwdA), e_fa);
    check_eq("FwdB", int'(FwdB), e_fb);
    check_eq("StallCount", int'(StallCount), e_sc);
  endtask

  // Clock edge: advance the model with the inputs present at the edge
  task automatic advance();
    @(posedge clock);
    if (reset) begin
      model_reset();
    end else begin
      if (e_pc == 1 && !m_halted && m_sc < SC_MAX) m_sc++;
      if (e_idex == 0) begin
        m_ers = (e_flush == 1) ? 5'd0 : D_Rs;
        m_ert = (e_flush == 1) ? 5'd0 : D_Rt;
      end
      if (!MemBusy) begin
        if (m_drain_left > 0) begin
          m_drain_left--;
          if (m_drain_left == 0) m_halted = 1'b1;
        end else if (!m_halted && e_lu == 0 && D_Halt) begin
          m_drain_left = DRAIN_CYCLES - 1;
          if (m_drain_left == 0) m_halted = 1'b1;
        end
      end
    end
    #1;
  endtask

  // Reset pulse between edges: effect must be immediate
  task automatic pulse_reset();
    reset = 1'b1;
    #1;
    check_eq("rst_halted", int'(Halted), 0);
    check_eq("rst_pc_stall", int'(PC_Stall), 0);
    check_eq("rst_flush", int'(ID_EXE_Flush), 0);
    reset = 1'b0;
    model_reset();
  endtask

  // Pulse D_Halt, optionally hold MemBusy, count cycles until Halted
  task automatic run_halt(input int busy_start, input int busy_len,
                          output int flushes, output int to_halt);
    flushes = 0;
    to_halt = -1;
    for (int c = 0; c < 40; c++) begin
      D_Halt  = (c == 0);
      MemBusy = (c >= busy_start && c < busy_start + busy_len);
      eval_check();
      if (Halted) begin
        to_halt = c;
        break;
      end
      if (ID_EXE_Flush && PC_Stall) flushes++;
      advance();
    end
    D_Halt  = 0;
    MemBusy = 0;
  endtask

  int flushes, to_halt, halted_run;

  initial begin
    clear_inputs();
    model_reset();
    reset = 1'b1;
    eval_check();
    advance();
    eval_check();
    advance();
    reset = 1'b0;
    eval_check();
    advance();

    // Load-use: one bubble, then clean once EXE holds the bubble
    E_ReadMem = 1; E_WriteReg = 1; E_REG = 5'd5; D_Rs = 5'd5; D_UseRs = 1;
    eval_check();
    check_eq("lu_flush", int'(ID_EXE_Flush), 1);
    advance();
    E_ReadMem = 0; E_WriteReg = 0; E_REG = 5'd0;
    eval_check();
    check_eq("lu_after", int'(PC_Stall), 0);
    advance();

    // No false hazard: reg 0 destination, or source not read
    E_ReadMem = 1; E_WriteReg = 1; E_REG = 5'd0; D_Rs = 5'd0;
    eval_check();
    check_eq("nohaz_r0", int'(PC_Stall), 0);
    advance();
    E_REG = 5'd9; D_Rs = 5'd9; D_UseRs = 0;
    eval_check();
    check_eq("nohaz_unused", int'(PC_Stall), 0);
    advance();
    clear_inputs();

    // Forwarding: capture E-stage Rs/Rt = 7, then vary MEM/WB writers
    D_Rs = 5'd7; D_Rt = 5'd7;
    eval_check();
    advance();
    M_REG = 5'd7; W_REG = 5'd7; M_WriteReg = 1; W_WriteReg = 1;
    eval_check();
    check_eq("fwd_mem", int'(FwdA), 1);
    advance();
    M_WriteReg = 0;
    eval_check();
    check_eq("fwd_wb", int'(FwdB), 2);
    advance();
    D_Rs = 5'd0; D_Rt = 5'd0; M_REG = 5'd0; W_REG = 5'd0; M_WriteReg = 1;
    eval_check();
    advance();
    eval_check();
    check_eq("fwd_r0", int'(FwdA), 0);
    advance();
    clear_inputs();

    // Halt: three drain cycles then Halted held
    run_halt(99, 0, flushes, to_halt);
    check_eq("halt_flushes", flushes, 3);
    check_eq("halt_latency", to_halt, 3);
    advance();
    for (int i = 0; i < 4; i++) begin
      eval_check();
      check_eq("halt_hold", int'(Halted), 1);
      advance();
    end

    // Reset in the middle of a drain
    pulse_reset();
    D_Halt = 1;
    eval_check();
    advance();
    D_Halt = 0;
    eval_check();
    pulse_reset();
    eval_check();
    check_eq("mid_drain_run", int'(PC_Stall), 0);
    advance();

    // MemBusy for 4 cycles during drain delays Halted by 4 cycles
    run_halt(1, 4, flushes, to_halt);
    check_eq("busy_latency", to_halt, 7);
    check_eq("busy_flushes", flushes, 3);
    advance();
    pulse_reset();

    // Stall count: three load-use bubbles plus a three-cycle drain
    for (int i = 0; i < 3; i++) begin
      E_ReadMem = 1; E_WriteReg = 1; E_REG = 5'd3; D_Rt = 5'd3; D_UseRt = 1;
      eval_check();
      advance();
      clear_inputs();
      eval_check();
      advance();
    end
    run_halt(99, 0, flushes, to_halt);
`ifdef HAZARD_STALL_COUNT_EN
    check_eq("stall_count", int'(StallCount), 6);
`else
    check_eq("stall_count", int'(StallCount), 0);
`endif
    advance();
    for (int i = 0; i < 3; i++) begin
      eval_check();
      advance();
    end
    pulse_reset();

    // Random traffic over a small register space to provoke hazards
    halted_run = 0;
    for (int i = 0; i < 3000; i++) begin
      D_Rs       = 5'($urandom_range(0, 3));
      D_Rt       = 5'($urandom_range(0, 3));
      D_UseRs    = 1'($urandom_range(0, 1));
      D_UseRt    = 1'($urandom_range(0, 1));
      D_Halt     = ($urandom_range(0, 39) == 0);
      E_ReadMem  = 1'($urandom_range(0, 1));
      E_WriteReg = ($urandom_range(0, 3) != 0);
      E_REG      = 5'($urandom_range(0, 3));
      M_WriteReg = 1'($urandom_range(0, 1));
      M_REG      = 5'($urandom_range(0, 3));
      W_WriteReg = 1'($urandom_range(0, 1));
      W_REG      = 5'($urandom_range(0, 3));
      MemBusy    = ($urandom_range(0, 7) == 0);
      halted_run = m_halted ? halted_run + 1 : 0;
      reset      = ($urandom_range(0, 99) == 0) || (halted_run > 5);
      eval_check();
      advance();
    end
    reset = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
